operand_fetch: RTL

Operand-fetch pipeline stage of the RISC-V core, sitting between decode and execute. It drives the register file's read addresses, takes the returned operands, and substitutes the same-cycle writeback value when it targets a source (bypass). A 32-entry pending-write scoreboard detects RAW/WAW hazards and stalls. Results are registered into a valid/ready output slot that feeds execute.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/opfetch_scoreboard.sv | 61 ++++++
 rtl/operand_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, register address width
// and the bit positions of the register fields inside a 32-bit instruction.
// Also provides a one-hot helper used to build register bitmasks.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Register field positions in the raw instruction word.
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  function automatic reg_mask_t addr_onehot(input reg_addr_t addr);
    reg_mask_t one;
    one = '0;
    one[0] = 1'b1;
    return one << addr;
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard for the operand-fetch stage.
// One bit per architectural register, set when a writing instruction issues
// and cleared when it writes back (or when it is flushed from the output slot).
// Bit 0 is hard-wired to 0 because x0 is never written.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   i_set_en / i_set_addr      mark a register as pending (issue)
//   i_clr_en / i_clr_addr      writeback clear
//   i_flush_en / i_flush_addr  clear for an instruction discarded by flush
//   i_rs1/rs2/rd_addr          lookup addresses
//   o_rs1/rs2/rd_pend          raw scoreboard bit for each lookup
//   o_sb                       full bitmask
module opfetch_scoreboard
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_set_en,
  input  reg_addr_t i_set_addr,
  input  logic      i_clr_en,
  input  reg_addr_t i_clr_addr,
  input  logic      i_flush_en,
  input  reg_addr_t i_flush_addr,
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  input  reg_addr_t i_rd_addr,
  output logic      o_rs1_pend,
  output logic      o_rs2_pend,
  output logic      o_rd_pend,
  output reg_mask_t o_sb
);

  reg_mask_t r_sb;
  reg_mask_t w_set_mask;
  reg_mask_t w_clr_mask;
  reg_mask_t w_sb_next;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en)   w_set_mask = addr_onehot(i_set_addr);
    if (i_clr_en)   w_clr_mask = w_clr_mask | addr_onehot(i_clr_addr);
    if (i_flush_en) w_clr_mask = w_clr_mask | addr_onehot(i_flush_addr);
    // Set is applied after clear: a newly issued writer is younger than the
    // one retiring in the same cycle, so its pending bit must survive.
    w_sb_next    = (r_sb & ~w_clr_mask) | w_set_mask;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_next;
  end

  assign o_rs1_pend = r_sb[i_rs1_addr];
  assign o_rs2_pend = r_sb[i_rs2_addr];
  assign o_rd_pend  = r_sb[i_rd_addr];
  assign o_sb       = r_sb;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch pipeline stage between decode and execute.
// Drives register-file read addresses straight from the instruction fields,
// resolves operands (x0 -> 0, optional writeback bypass, else rf data),
// stalls on RAW/WAW hazards tracked by a pending-write scoreboard, and
// registers the result into a single valid/ready output slot.
//
// Handshake: a transfer happens on a cycle where valid and ready are both 1.
// in_valid/in_ready move a decoded instruction into the slot; out_valid/
// out_ready move the slot into execute. The slot holds steady while
// out_valid && !out_ready.
//
// Build option: OPFETCH_BYPASS_EN enables the writeback bypass mux and lets a
// source whose pending bit retires this cycle issue immediately. Without it,
// a source matching the current writeback stalls one extra cycle.
//
// Ports: clk/rst, decode side (in_*), register file (rf_*), writeback (wb_*),
// flush, execute side (out_*), stall_cnt performance counter.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   in_uses_rs1,
  input  logic                   in_uses_rs2,
  input  logic                   in_rd_we,
  output logic [4:0]             rf_rs1_addr,
  output logic [4:0]             rf_rs2_addr,
  input  logic [XLEN-1:0]        rf_rs1_data,
  input  logic [XLEN-1:0]        rf_rs2_data,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd_addr,
  input  logic [XLEN-1:0]        wb_rd_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_rs1_val,
  output logic [XLEN-1:0]        out_rs2_val,
  output logic [4:0]             out_rd_addr,
  output logic                   out_rd_we,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  reg_addr_t w_rs1_addr, w_rs2_addr, w_rd_addr;
  logic      w_sb_rs1, w_sb_rs2, w_sb_rd;
  logic      w_wb_hit_rs1, w_wb_hit_rs2;
  logic      w_rs1_pend, w_rs2_pend, w_rd_pend;
  logic      w_hazard, w_in_ready, w_fire;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  reg_mask_t w_sb_unused;

  logic                   r_out_valid;
  logic [XLEN-1:0]        r_out_pc;
  logic [31:0]            r_out_instr;
  logic [XLEN-1:0]        r_out_rs1_val;
  logic [XLEN-1:0]        r_out_rs2_val;
  reg_addr_t              r_out_rd_addr;
  logic                   r_out_rd_we;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_rs1_addr  = in_instr[RS1_LSB +: REG_ADDR_W];
  assign w_rs2_addr  = in_instr[RS2_LSB +: REG_ADDR_W];
  assign w_rd_addr   = in_instr[RD_LSB  +: REG_ADDR_W];
  assign rf_rs1_addr = w_rs1_addr;
  assign rf_rs2_addr = w_rs2_addr;

  assign w_wb_hit_rs1 = wb_valid && (wb_rd_addr == w_rs1_addr);
  assign w_wb_hit_rs2 = wb_valid && (wb_rd_addr == w_rs2_addr);

`ifdef OPFETCH_BYPASS_EN
  // The writeback retiring this cycle is forwarded, so it no longer blocks.
  assign w_rs1_pend = in_uses_rs1 && (w_rs1_addr != '0) && w_sb_rs1 && !w_wb_hit_rs1;
  assign w_rs2_pend = in_uses_rs2 && (w_rs2_addr != '0) && w_sb_rs2 && !w_wb_hit_rs2;

  // The rf returns the pre-write value during its write cycle, hence the bypass.
  assign w_rs1_val = (w_rs1_addr == '0) ? '0 : (w_wb_hit_rs1 ? wb_rd_data : rf_rs1_data);
  assign w_rs2_val = (w_rs2_addr == '0) ? '0 : (w_wb_hit_rs2 ? wb_rd_data : rf_rs2_data);
`else
  // No forwarding: wait until the rf holds the written value (one cycle later).
  assign w_rs1_pend = in_uses_rs1 && (w_rs1_addr != '0) && (w_sb_rs1 || w_wb_hit_rs1);
  assign w_rs2_pend = in_uses_rs2 && (w_rs2_addr != '0) && (w_sb_rs2 || w_wb_hit_rs2);

  assign w_rs1_val = (w_rs1_addr == '0) ? '0 : rf_rs1_data;
  assign w_rs2_val = (w_rs2_addr == '0) ? '0 : rf_rs2_data;

  // Writeback data only feeds the bypass mux, absent in this build.
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_rd_data;
`endif

  // WAW: keep at most one outstanding write per register.
  assign w_rd_pend  = in_rd_we && (w_rd_addr != '0) && w_sb_rd;
  assign w_hazard   = w_rs1_pend || w_rs2_pend || w_rd_pend;
  assign w_in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_fire     = in_valid && w_in_ready;

  opfetch_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_set_en     (w_fire && in_rd_we && (w_rd_addr != '0)),
    .i_set_addr   (w_rd_addr),
    .i_clr_en     (wb_valid),
    .i_clr_addr   (wb_rd_addr),
    .i_flush_en   (flush && r_out_valid && r_out_rd_we),
    .i_flush_addr (r_out_rd_addr),
    .i_rs1_addr   (w_rs1_addr),
    .i_rs2_addr   (w_rs2_addr),
    .i_rd_addr    (w_rd_addr),
    .o_rs1_pend   (w_sb_rs1),
    .o_rs2_pend   (w_sb_rs2),
    .o_rd_pend    (w_sb_rd),
    .o_sb         (w_sb_unused)
  );

  // Output slot. flush blocks in_ready, so it never races a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_instr   <= '0;
      r_out_rs1_val <= '0;
      r_out_rs2_val <= '0;
      r_out_rd_addr <= '0;
      r_out_rd_we   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= in_pc;
      r_out_instr   <= in_instr;
      r_out_rs1_val <= w_rs1_val;
      r_out_rs2_val <= w_rs2_val;
      r_out_rd_addr <= w_rd_addr;
      r_out_rd_we   <= in_rd_we;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign out_rs1_val = r_out_rs1_val;
  assign out_rs2_val = r_out_rs2_val;
  assign out_rd_addr = r_out_rd_addr;
  assign out_rd_we   = r_out_rd_we;
  assign stall_cnt   = r_stall_cnt;

endmodule
